pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Each pipeline stage adds one CHUNK-bit slice, and the carry is registered between stages.
- Operand transfer uses a valid/ready handshake on both sides. The pipeline accepts one operation per cycle when not stalled.
- It is the general arithmetic primitive for wide datapaths, replacing fixed-width combinational adders where timing requires it.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage.
- STAGES, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0; ignored when sub=1.
- sub  input  1  0 computes a+b+carry_in; 1 computes a-b, implemented as a+~b+1.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  sum or difference.
- carry_out  output  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Reset (asynchronous, immediate):
  - All stage valid bits, out_valid, out, carry_out and overflow clear to 0.
  - All operand skew registers clear to 0.
  - in_ready is 0 while reset is high.
- advance = !out_valid || out_ready. This is one global enable; all stages shift together.
- in_ready = advance && !reset, combinational.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage k, for k = 0..STAGES-1:
  - Adds bits [k*CHUNK +: CHUNK] of a and b_eff, plus the registered carry from stage k-1. Stage 0 uses c0 instead.
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : carry_in.
- Skew registers:
  - Upper operand slices are delayed so each slice meets its carry.
  - Completed lower result slices are delayed so all slices emerge together.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall. At defaults this is 4.
- Throughput: 1 operation per cycle with out_ready held high. Results leave in acceptance order.
- Stall behaviour:
  - When out_valid=1 and out_ready=0, every register holds its value and in_ready=0.
  - out, carry_out and overflow stay stable until the result transfers.
- Bubbles:
  - A cycle with in_valid=0 while advancing inserts an invalid bubble.
  - Data registers of a bubble stage may update freely; only the valid bits are meaningful.
- Simultaneous events: output and input transfers in the same cycle are legal. The pipeline shifts by one.
- Wrap-around: results are modulo 2^WIDTH, with carry_out and overflow reported alongside.
- Reset mid-operation: all in-flight operations are discarded and nothing is emitted. The first operand after reset deasserts yields its result after STAGES cycles.
- Degenerate case: CHUNK=WIDTH gives STAGES=1, a single registered adder with latency 1.
- Elaboration must fail if WIDTH % CHUNK != 0.

Decomposition:
- No shared package is needed. STAGES and the skew lengths are localparams inside the module.
- Sub-module adder_chunk (parameter CHUNK; inputs a, b, carry_in; outputs sum, carry_out, carry_msb_in):
  - Combinational CHUNK-bit ripple chain of the existing full_adder cells.
  - carry_msb_in is used by the top stage for overflow.
- The pipeline registers, skew logic and handshake live in pipelined_adder, instantiated via a generate loop over STAGES.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: assert reset mid-cycle with no clock edge -> out_valid=0, out=0x0000, carry_out=0, overflow=0 immediately; in_ready=0 during reset, 1 after.
- Single add: a=0x00FF, b=0x0001, carry_in=0, sub=0 -> 4 cycles later out=0x0100, carry_out=0, overflow=0.
- Unsigned wrap: a=0xFFFF, b=0x0001 -> out=0x0000, carry_out=1, overflow=0. Signed overflow: a=0x7FFF, b=0x0001 -> out=0x8000, carry_out=0, overflow=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, carry_in=1 -> out=0xFFFE, carry_out=0, overflow=0. Also a=0x8000, b=0x0001, sub=1 -> out=0x7FFF, carry_out=1, overflow=1.
- Backpressure streaming: 8 back-to-back ops with a=i, b=0x1000*i, i=1..8, and out_ready toggling pseudo-randomly -> 8 results out=0x1001*i, in order, no loss or duplication; outputs stable while stalled; in_ready=0 whenever out_valid && !out_ready.
- Reset mid-stream: issue 3 ops, assert reset 2 cycles later -> no result emitted; a new op 0x1234+0x1111 after release gives out=0x2345 after exactly 4 cycles.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults for the pipelined adder slice.
// The top module imports these as its parameter defaults.
package pipelined_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// carry_msb_in exposes the carry into the top bit so the last stage can flag signed overflow.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (c[i]),
            .sum       (sum[i]),
            .carry_out (c[i+1])
        );
    end

    assign carry_out    = c[CHUNK];
    assign carry_msb_in = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of each ripple chunk.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, valid/ready on both sides with a single global advance enable.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    logic              advance;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] lane_cout;
    logic              ovf_q, ovf_d;
    logic              top_msb_c;
    logic [WIDTH-1:0]  result;

    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance && !reset;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | carry_in;

    // Bubbles still clock carry/ovf forward; only the valid bits carry meaning.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (advance) begin
            valid_d[0] = in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
            end
            carry_d = lane_cout;
            ovf_d   = top_msb_c ^ lane_cout[STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Lane j: operand slice delayed j cycles to meet its carry, then its sum slice
    // delayed STAGES-j cycles (including the stage register) so all slices align.
    for (genvar j = 0; j < STAGES; j++) begin : g_lane
        localparam int unsigned DLY = j;
        localparam int unsigned SD  = STAGES - j;

        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic             cin;
        logic [CHUNK-1:0] sum_c;
        logic             cout_c;
        logic [CHUNK-1:0] sum_q [SD];
        logic [CHUNK-1:0] sum_d [SD];

        if (j == 0) begin : g_head
            assign op_a = a[CHUNK-1:0];
            assign op_b = b_eff[CHUNK-1:0];
            assign cin  = c0;
        end else begin : g_skew
            logic [CHUNK-1:0] op_a_q [DLY];
            logic [CHUNK-1:0] op_a_d [DLY];
            logic [CHUNK-1:0] op_b_q [DLY];
            logic [CHUNK-1:0] op_b_d [DLY];

            always_comb begin
                op_a_d = op_a_q;
                op_b_d = op_b_q;
                if (advance) begin
                    op_a_d[0] = a[j*CHUNK +: CHUNK];
                    op_b_d[0] = b_eff[j*CHUNK +: CHUNK];
                    for (int unsigned i = 1; i < DLY; i++) begin
                        op_a_d[i] = op_a_q[i-1];
                        op_b_d[i] = op_b_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    op_a_q <= '{default: '0};
                    op_b_q <= '{default: '0};
                end else begin
                    op_a_q <= op_a_d;
                    op_b_q <= op_b_d;
                end
            end

            assign op_a = op_a_q[DLY-1];
            assign op_b = op_b_q[DLY-1];
            assign cin  = carry_q[j-1];
        end

        if (j == STAGES - 1) begin : g_top
            adder_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a            (op_a),
                .b            (op_b),
                .carry_in     (cin),
                .sum          (sum_c),
                .carry_out    (cout_c),
                .carry_msb_in (top_msb_c)
            );
        end else begin : g_mid
            logic msb_c_unused;
            adder_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a            (op_a),
                .b            (op_b),
                .carry_in     (cin),
                .sum          (sum_c),
                .carry_out    (cout_c),
                .carry_msb_in (msb_c_unused)
            );
        end

        assign lane_cout[j] = cout_c;

        always_comb begin
            sum_d = sum_q;
            if (advance) begin
                sum_d[0] = sum_c;
                for (int unsigned i = 1; i < SD; i++) begin
                    sum_d[i] = sum_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sum_q <= '{default: '0};
            end else begin
                sum_q <= sum_d;
            end
        end

        assign result[j*CHUNK +: CHUNK] = sum_q[SD-1];
    end

    assign out_valid = valid_q[STAGES-1];
    assign out       = result;
    assign carry_out = carry_q[STAGES-1];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder at WIDTH=16, CHUNK=4: vector table,
// hand-written reset/stall sequences, and randomized streams against an arithmetic model.
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] out;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        carry_out;
    logic        overflow;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic vec_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s);
        vec_t        v;
        int unsigned ux;
        int unsigned uy;
        int          sx;
        int          sy;
        int unsigned ur;
        int          sr;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            ur = ux + 32'd65536 - uy;
            sr = sx - sy;
        end else begin
            ur = ux + uy + int'(ci);
            sr = sx + sy + int'(ci);
        end
        v.a   = x;
        v.b   = y;
        v.cin = ci;
        v.sub = s;
        v.out = 16'(ur % 32'd65536);
        v.co  = (ur >= 32'd65536);
        v.ovf = (sr > 32767) || (sr < -32768);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned lat;
        bit          seen;
        @(negedge clk);
        a         = v.a;
        b         = v.b;
        carry_in  = v.cin;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_out"}, 32'(out), 32'(v.out));
        chk({tag, "_carry_out"}, 32'(carry_out), 32'(v.co));
        chk({tag, "_overflow"}, 32'(overflow), 32'(v.ovf));
    endtask

    task automatic stream(input vec_t ops[$], input bit gaps, input bit rand_ready,
                          input string tag, output int unsigned cycles);
        vec_t        exp_q[$];
        vec_t        e;
        int unsigned sent;
        int unsigned got;
        int unsigned cyc;
        int unsigned extra;
        bit          prev_stall;
        logic [15:0] prev_out;
        logic        prev_co;
        logic        prev_ovf;
        sent       = 0;
        got        = 0;
        cyc        = 0;
        extra      = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_co    = 1'b0;
        prev_ovf   = 1'b0;
        while (got < ops.size() && cyc < 4 * ops.size() + 100) begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < ops.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                a        = ops[sent].a;
                b        = ops[sent].b;
                carry_in = ops[sent].cin;
                sub      = ops[sent].sub;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            cyc++;
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_stall_out"}, 32'(out), 32'(prev_out));
                chk({tag, "_stall_co"}, 32'(carry_out), 32'(prev_co));
                chk({tag, "_stall_ovf"}, 32'(overflow), 32'(prev_ovf));
            end
            chk({tag, "_in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (in_valid && in_ready) begin
                exp_q.push_back(ops[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_result"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_out"}, 32'(out), 32'(e.out));
                    chk({tag, "_carry_out"}, 32'(carry_out), 32'(e.co));
                    chk({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            prev_co    = carry_out;
            prev_ovf   = overflow;
        end
        cycles = cyc;
        chk({tag, "_count"}, got, ops.size());
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        chk({tag, "_no_duplicates"}, extra, 32'd0);
    endtask

    initial begin
        vec_t        tbl[11];
        vec_t        ops[$];
        vec_t        v;
        int unsigned cycles;
        int unsigned emitted;
        int unsigned waitc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_carry_out", 32'(carry_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        tbl[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        tbl[6]  = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
        tbl[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[10] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Stalled result, then reset asserted between clock edges.
        @(negedge clk);
        a         = 16'h8000;
        b         = 16'hFFFF;
        carry_in  = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        waitc     = 0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        while (!out_valid && waitc < 20) begin
            @(negedge clk);
            waitc++;
            #1;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_out", 32'(out), 32'h7FFF);
        chk("stall_hold_co", 32'(carry_out), 32'd1);
        chk("stall_hold_ovf", 32'(overflow), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_co", 32'(carry_out), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1 chk("async_rel_in_ready", 32'(in_ready), 32'd1);

        // Directed back-to-back stream under pseudo-random backpressure.
        ops.delete();
        for (int i = 1; i <= 8; i++) begin
            v.a   = 16'(i);
            v.b   = 16'(32'h1000 * i);
            v.cin = 1'b0;
            v.sub = 1'b0;
            v.out = 16'(32'h1001 * i);
            v.co  = 1'b0;
            v.ovf = 1'b0;
            ops.push_back(v);
        end
        stream(ops, 1'b0, 1'b1, "bp8", cycles);

        // Random operands, random gaps and backpressure.
        ops.delete();
        for (int i = 0; i < 150; i++) begin
            ops.push_back(model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1))));
        end
        stream(ops, 1'b1, 1'b1, "rand", cycles);

        // Full throughput: one result per cycle once the pipe fills.
        ops.delete();
        for (int i = 0; i < 20; i++) begin
            ops.push_back(model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1))));
        end
        stream(ops, 1'b0, 1'b0, "thru", cycles);
        chk("thru_cycles", cycles, 32'd24);

        // Reset mid-stream discards in-flight work.
        emitted   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a        = 16'(32'h0101 * (i + 1));
            b        = 16'h0202;
            carry_in = 1'b0;
            sub      = 1'b0;
            in_valid = 1'b1;
            #1;
            if (out_valid) emitted++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (out_valid) emitted++;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) emitted++;
            @(negedge clk);
        end
        chk("midrst_emitted", emitted, 32'd0);
        v = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        run_vec(v, "midrst_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
